// File: rtl/trim_pkg.sv
// Shared types and helpers for the trim_mux gain-trim engine: FSM state encoding,
// channel index width and the round-half-up / overflow helper.
package trim_pkg;

    // Sized for the largest supported channel count so one encoding fits every build.
    localparam int MAX_CHANNELS   = 16;
    localparam int CHAN_IDX_WIDTH = $clog2(MAX_CHANNELS);
    localparam int PROD_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } trim_state_t;

    typedef struct packed {
        logic [PROD_MAX_WIDTH-1:0] value;
        logic                      overflow;
    } round_result_t;

    // Drops frac_bits, adds the first discarded bit back in at full width so a
    // rounding carry is never lost, then flags anything at or above mag_width.
    function automatic round_result_t round_product(
        input logic [PROD_MAX_WIDTH-1:0] product,
        input int                        frac_bits,
        input int                        mag_width
    );
        logic [PROD_MAX_WIDTH-1:0] sum;
        round_result_t             result;
        sum = (product >> frac_bits)
            + {{(PROD_MAX_WIDTH-1){1'b0}}, product[frac_bits-1]};
        result.overflow = |(sum >> mag_width);
        result.value    = sum & ~({PROD_MAX_WIDTH{1'b1}} << mag_width);
        return result;
    endfunction

endpackage

// File: rtl/trim_mult.sv
// Unsigned A_WIDTH x B_WIDTH multiplier with NUM_PIPELINE_LEVELS output registers.
// Pure datapath: no reset, validity is tracked by the caller's tag pipeline.
module trim_mult #(
    parameter int A_WIDTH             = 26,
    parameter int B_WIDTH             = 27,
    parameter int NUM_PIPELINE_LEVELS = 6
) (
    input  logic                       clk,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic [A_WIDTH+B_WIDTH-1:0] p
);

    logic [A_WIDTH+B_WIDTH-1:0] pipe [NUM_PIPELINE_LEVELS];

    always_ff @(posedge clk) begin
        pipe[0] <= {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
        for (int k = 1; k < NUM_PIPELINE_LEVELS; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end

    assign p = pipe[NUM_PIPELINE_LEVELS-1];

endmodule

// File: rtl/trim_mux.sv
// Time-multiplexed per-channel gain trim using a single pipelined multiplier.
// Define TRIM_SATURATE_EN to clip overflowing channels to all ones; otherwise results wrap.
module trim_mux
    import trim_pkg::*;
#(
    parameter int CHANNEL_COUNT  = 4,
    parameter int MAG_WIDTH      = 26,
    parameter int GAIN_WIDTH     = 27,
    parameter int GAIN_FRAC_BITS = 26,
    parameter int MULT_LATENCY   = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               strobe,
    input  logic [MAG_WIDTH*CHANNEL_COUNT-1:0]  magnitudes,
    input  logic [GAIN_WIDTH*CHANNEL_COUNT-1:0] gains,
    input  logic                               overrunClear,
    output logic                               busy,
    output logic [MAG_WIDTH*CHANNEL_COUNT-1:0]  trimmed,
    output logic                               trimmedValid,
    output logic                               trimmedToggle,
    output logic [CHANNEL_COUNT-1:0]           saturated,
    output logic                               overrun
);

    localparam int PROD_WIDTH = MAG_WIDTH + GAIN_WIDTH;
    localparam logic [CHAN_IDX_WIDTH-1:0] LAST_IDX = CHAN_IDX_WIDTH'(CHANNEL_COUNT - 1);

    trim_state_t               state, state_next;
    logic [CHAN_IDX_WIDTH-1:0] chan_cnt, chan_cnt_next;
    logic                      accept, issue, finish;

    logic [MAG_WIDTH-1:0]      snap_mag  [CHANNEL_COUNT];
    logic [GAIN_WIDTH-1:0]     snap_gain [CHANNEL_COUNT];
    logic [MAG_WIDTH-1:0]      sel_mag, op_mag;
    logic [GAIN_WIDTH-1:0]     sel_gain, op_gain;

    logic                      op_valid;
    logic [CHAN_IDX_WIDTH-1:0] op_idx;
    logic [MULT_LATENCY-1:0]   tag_valid;
    logic [CHAN_IDX_WIDTH-1:0] tag_idx [MULT_LATENCY];
    logic                      out_valid;
    logic [CHAN_IDX_WIDTH-1:0] out_idx;

    logic [PROD_WIDTH-1:0]     product;
    round_result_t             rounded;
    logic                      rounded_unused;
    logic [MAG_WIDTH-1:0]      result;
    logic [MAG_WIDTH-1:0]      staging [CHANNEL_COUNT];

    assign busy      = (state != IDLE);
    assign out_valid = tag_valid[MULT_LATENCY-1];
    assign out_idx   = tag_idx[MULT_LATENCY-1];
    assign finish    = out_valid && (out_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            chan_cnt <= '0;
        end else begin
            state    <= state_next;
            chan_cnt <= chan_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        chan_cnt_next = chan_cnt;
        accept        = 1'b0;
        issue         = 1'b0;
        unique case (state)
            IDLE: begin
                if (strobe) begin
                    accept        = 1'b1;
                    state_next    = ISSUE;
                    chan_cnt_next = '0;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (chan_cnt == LAST_IDX) begin
                    state_next = DRAIN;
                end else begin
                    chan_cnt_next = chan_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Snapshot lets the upstream stage move on as soon as the strobe is taken.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                snap_mag[k]  <= magnitudes[k*MAG_WIDTH +: MAG_WIDTH];
                snap_gain[k] <= gains[k*GAIN_WIDTH +: GAIN_WIDTH];
            end
        end
    end

    always_comb begin
        sel_mag  = '0;
        sel_gain = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            if (chan_cnt == CHAN_IDX_WIDTH'(k)) begin
                sel_mag  = snap_mag[k];
                sel_gain = snap_gain[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        op_mag  <= sel_mag;
        op_gain <= sel_gain;
    end

    // Tags ride alongside the multiplier so each product knows its channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid  <= 1'b0;
            op_idx    <= '0;
            tag_valid <= '0;
            for (int k = 0; k < MULT_LATENCY; k++) begin
                tag_idx[k] <= '0;
            end
        end else begin
            op_valid     <= issue;
            op_idx       <= chan_cnt;
            tag_valid[0] <= op_valid;
            tag_idx[0]   <= op_idx;
            for (int k = 1; k < MULT_LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_idx[k]   <= tag_idx[k-1];
            end
        end
    end

    trim_mult #(
        .A_WIDTH             (MAG_WIDTH),
        .B_WIDTH             (GAIN_WIDTH),
        .NUM_PIPELINE_LEVELS (MULT_LATENCY)
    ) u_mult (
        .clk (clk),
        .a   (op_mag),
        .b   (op_gain),
        .p   (product)
    );

    assign rounded        = round_product(PROD_MAX_WIDTH'(product), GAIN_FRAC_BITS, MAG_WIDTH);
    assign rounded_unused = ^{rounded.value[PROD_MAX_WIDTH-1:MAG_WIDTH], rounded.overflow};

`ifdef TRIM_SATURATE_EN
    logic                     result_sat;
    logic [CHANNEL_COUNT-1:0] staging_sat;
    logic [CHANNEL_COUNT-1:0] sat_q;

    assign result     = rounded.overflow ? '1 : rounded.value[MAG_WIDTH-1:0];
    assign result_sat = rounded.overflow;
    assign saturated  = sat_q;

    always_ff @(posedge clk) begin
        if (out_valid) begin
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                if (out_idx == CHAN_IDX_WIDTH'(k)) begin
                    staging_sat[k] <= result_sat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else if (finish) begin
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                sat_q[k] <= (k == CHANNEL_COUNT - 1) ? result_sat : staging_sat[k];
            end
        end
    end
`else
    assign result    = rounded.value[MAG_WIDTH-1:0];
    assign saturated = '0;
`endif

    always_ff @(posedge clk) begin
        if (out_valid) begin
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                if (out_idx == CHAN_IDX_WIDTH'(k)) begin
                    staging[k] <= result;
                end
            end
        end
    end

    // The last channel bypasses staging so the whole set lands on one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trimmed       <= '0;
            trimmedValid  <= 1'b0;
            trimmedToggle <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            trimmedValid <= finish;
            if (finish) begin
                trimmedToggle <= ~trimmedToggle;
                for (int k = 0; k < CHANNEL_COUNT; k++) begin
                    trimmed[k*MAG_WIDTH +: MAG_WIDTH] <= (k == CHANNEL_COUNT - 1) ? result : staging[k];
                end
            end
            if (strobe && busy) begin
                overrun <= 1'b1;
            end else if (overrunClear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trim_mux.sv
// Self-checking bench for trim_mux: constant vector table, randomized runs against an
// arithmetic reference model, and hand-written overrun / back-to-back / reset sequences.
module tb_trim_mux;

    localparam int CH          = 4;
    localparam int MW          = 26;
    localparam int GW          = 27;
    localparam int FRAC        = 26;
    localparam int LAT         = 6;
    localparam int CONV_CYCLES = CH + LAT + 1;
    localparam int TIMEOUT     = 100;

    typedef logic [CH-1:0][MW-1:0] mag_vec_t;
    typedef logic [CH-1:0][GW-1:0] gain_vec_t;

    typedef struct packed {
        mag_vec_t        mag;
        gain_vec_t       gain;
        mag_vec_t        exp_val;
        logic [CH-1:0]   exp_sat;
    } vec_t;

`ifdef TRIM_SATURATE_EN
    localparam logic [MW-1:0] OVF_VAL = 26'h3FFFFFF;
    localparam logic          OVF_SAT = 1'b1;
`else
    localparam logic [MW-1:0] OVF_VAL = 26'h3FFFFFD;
    localparam logic          OVF_SAT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          strobe;
    mag_vec_t      magnitudes;
    gain_vec_t     gains;
    logic          overrunClear;
    logic          busy;
    mag_vec_t      trimmed;
    logic          trimmedValid;
    logic          trimmedToggle;
    logic [CH-1:0] saturated;
    logic          overrun;

    int assert_count = 0;
    int fail_count   = 0;

    vec_t vectors [3];

    trim_mux #(
        .CHANNEL_COUNT  (CH),
        .MAG_WIDTH      (MW),
        .GAIN_WIDTH     (GW),
        .GAIN_FRAC_BITS (FRAC),
        .MULT_LATENCY   (LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .strobe        (strobe),
        .magnitudes    (magnitudes),
        .gains         (gains),
        .overrunClear  (overrunClear),
        .busy          (busy),
        .trimmed       (trimmed),
        .trimmedValid  (trimmedValid),
        .trimmedToggle (trimmedToggle),
        .saturated     (saturated),
        .overrun       (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: real-valued mag*gain/2^FRAC, rounded half up, then clipped or wrapped.
    function automatic void refTrim(input logic [MW-1:0] m, input logic [GW-1:0] g,
                                    output logic [MW-1:0] v, output logic s);
        longint unsigned p, unity, q, rem, sum, limit;
        p     = 64'(m) * 64'(g);
        unity = 64'd1 << FRAC;
        q     = p / unity;
        rem   = p % unity;
        sum   = q + ((rem >= unity / 2) ? 64'd1 : 64'd0);
        limit = 64'd1 << MW;
        s     = 1'b0;
        v     = MW'(sum % limit);
`ifdef TRIM_SATURATE_EN
        if (sum >= limit) begin
            v = '1;
            s = 1'b1;
        end
`endif
    endfunction

    task automatic applyStimulus(input mag_vec_t m, input gain_vec_t g);
        magnitudes = m;
        gains      = g;
        strobe     = 1'b1;
        tick();
        strobe = 1'b0;
        for (int c = 0; c < CH; c++) begin
            magnitudes[c] = MW'($urandom);
            gains[c]      = GW'($urandom);
        end
    endtask

    task automatic waitForValid(output int latency, output int busy_cycles);
        latency     = 0;
        busy_cycles = 0;
        while (!trimmedValid && latency < TIMEOUT) begin
            if (busy) busy_cycles++;
            tick();
            latency++;
        end
    endtask

    task automatic countValid(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (trimmedValid) pulses++;
        end
    endtask

    task automatic checkExpected(input string tag, input mag_vec_t exp_v, input logic [CH-1:0] exp_s);
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("%s_val%0d", tag, c), trimmed[c], exp_v[c]);
        end
        checkOutput({tag, "_sat"}, saturated, exp_s);
    endtask

    task automatic checkModel(input string tag, input mag_vec_t m, input gain_vec_t g);
        mag_vec_t      exp_v;
        logic [CH-1:0] exp_s;
        for (int c = 0; c < CH; c++) begin
            refTrim(m[c], g[c], exp_v[c], exp_s[c]);
        end
        checkExpected(tag, exp_v, exp_s);
    endtask

    initial begin
        int        lat, bcy, pulses;
        logic      prev_toggle;
        mag_vec_t  ma, mb;
        gain_vec_t ga, gb;

        rst_n        = 1'b0;
        strobe       = 1'b0;
        overrunClear = 1'b0;
        magnitudes   = '0;
        gains        = '0;

        vectors[0].mag     = {26'd4000, 26'd3000, 26'd2000, 26'd1000};
        vectors[0].gain    = {4{27'h4000000}};
        vectors[0].exp_val = {26'd4000, 26'd3000, 26'd2000, 26'd1000};
        vectors[0].exp_sat = 4'b0000;
        vectors[1].mag     = {26'd0, 26'd1, 26'd2, 26'd3};
        vectors[1].gain    = {4{27'h2000000}};
        vectors[1].exp_val = {26'd0, 26'd1, 26'd1, 26'd2};
        vectors[1].exp_sat = 4'b0000;
        vectors[2].mag     = {26'd7, 26'h3FFFFFF, 26'd100, 26'h3FFFFFF};
        vectors[2].gain    = {27'h2000000, 27'h4000000, 27'h6000000, 27'h7FFFFFF};
        vectors[2].exp_val = {26'd4, 26'h3FFFFFF, 26'd150, OVF_VAL};
        vectors[2].exp_sat = {3'b000, OVF_SAT};

        repeat (3) tick();
        checkOutput("rst_trimmed_lo", trimmed[1:0], 0);
        checkOutput("rst_trimmed_hi", trimmed[3:2], 0);
        checkOutput("rst_saturated", saturated, 0);
        checkOutput("rst_valid", trimmedValid, 0);
        checkOutput("rst_toggle", trimmedToggle, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            prev_toggle = trimmedToggle;
            applyStimulus(vectors[i].mag, vectors[i].gain);
            checkOutput($sformatf("vec%0d_busy_start", i), busy, 1);
            waitForValid(lat, bcy);
            checkOutput($sformatf("vec%0d_latency", i), lat, CONV_CYCLES);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bcy, CONV_CYCLES);
            checkOutput($sformatf("vec%0d_busy_end", i), busy, 0);
            checkOutput($sformatf("vec%0d_toggle", i), trimmedToggle, !prev_toggle);
            checkExpected($sformatf("vec%0d", i), vectors[i].exp_val, vectors[i].exp_sat);
            tick();
            checkOutput($sformatf("vec%0d_valid_pulse", i), trimmedValid, 0);
            checkOutput($sformatf("vec%0d_held", i), trimmed[0], vectors[i].exp_val[0]);
        end

        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < CH; c++) begin
                ma[c] = ($urandom_range(0, 3) == 0) ? MW'($urandom_range(0, 15)) : MW'($urandom);
                ga[c] = GW'($urandom);
            end
            applyStimulus(ma, ga);
            waitForValid(lat, bcy);
            checkOutput($sformatf("rnd%0d_latency", i), lat, CONV_CYCLES);
            checkModel($sformatf("rnd%0d", i), ma, ga);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Overrun: second strobe five edges in is dropped, first snapshot wins.
        ma = {26'd11, 26'd22, 26'd33, 26'd44};
        ga = {4{27'h4000000}};
        mb = {26'd55, 26'd66, 26'd77, 26'd88};
        gb = {4{27'h2000000}};
        applyStimulus(ma, ga);
        repeat (4) tick();
        magnitudes = mb;
        gains      = gb;
        strobe     = 1'b1;
        tick();
        strobe = 1'b0;
        checkOutput("ovr_flag", overrun, 1);
        waitForValid(lat, bcy);
        checkOutput("ovr_latency", lat, CONV_CYCLES - 5);
        checkModel("ovr_first", ma, ga);
        countValid(15, pulses);
        checkOutput("ovr_extra_valid", pulses, 0);
        checkOutput("ovr_sticky", overrun, 1);
        overrunClear = 1'b1;
        tick();
        overrunClear = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);

        // Set and clear on the same edge: set must win.
        applyStimulus(ma, ga);
        tick();
        strobe       = 1'b1;
        overrunClear = 1'b1;
        tick();
        strobe       = 1'b0;
        overrunClear = 1'b0;
        checkOutput("ovr_set_wins", overrun, 1);
        waitForValid(lat, bcy);
        overrunClear = 1'b1;
        tick();
        overrunClear = 1'b0;
        checkOutput("ovr_cleared2", overrun, 0);
        tick();

        // Back-to-back at the minimum period.
        applyStimulus(ma, ga);
        waitForValid(lat, bcy);
        checkOutput("b2b_first_latency", lat, CONV_CYCLES);
        applyStimulus(mb, gb);
        checkOutput("b2b_accepted", busy, 1);
        checkOutput("b2b_no_overrun", overrun, 0);
        waitForValid(lat, bcy);
        checkOutput("b2b_second_latency", lat, CONV_CYCLES);
        checkModel("b2b_second", mb, gb);

        // Reset mid-conversion aborts without a valid pulse.
        tick();
        applyStimulus(mb, ga);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midrst_busy", busy, 0);
        countValid(20, pulses);
        checkOutput("midrst_no_valid", pulses, 0);
        checkOutput("midrst_trimmed_lo", trimmed[1:0], 0);
        checkOutput("midrst_trimmed_hi", trimmed[3:2], 0);
        checkOutput("midrst_saturated", saturated, 0);
        checkOutput("midrst_toggle", trimmedToggle, 0);
        checkOutput("midrst_overrun", overrun, 0);
        applyStimulus(vectors[2].mag, vectors[2].gain);
        waitForValid(lat, bcy);
        checkOutput("midrst_after_latency", lat, CONV_CYCLES);
        checkOutput("midrst_after_toggle", trimmedToggle, 1);
        checkExpected("midrst_after", vectors[2].exp_val, vectors[2].exp_sat);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
